// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU accesses pass straight through; a secondary
// word-access port is granted in CPU-idle cycles, with a starvation hold toward the core.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 16,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_memwrite,
  input  logic        cpu_memread,
  input  logic [3:0]  cpu_sign_mask,
  output logic [31:0] cpu_rdata,
  output logic        cpu_hold,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic [3:0]  dbg_sign_mask,
  output logic        dbg_gnt,
  output logic [31:0] dbg_rdata,
  output logic        dbg_rvalid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             hold_reg, hold_next;
  logic [31:0]      rdata_reg;
  logic             rvalid_reg;
  logic             cpu_active;
  logic             grant;

  assign cpu_active = cpu_memread | cpu_memwrite;

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      hold_reg   <= 1'b0;
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      hold_reg   <= hold_next;
      rvalid_reg <= (state_reg == S_RESP);
      if (state_reg == S_RESP) begin
        rdata_reg <= mem_rdata;
      end
    end
  end

  // Next-state logic; the counter saturates at LIMIT, which is also when hold is raised.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hold_next  = hold_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (dbg_req) begin
          state_next = S_WAIT;
          cnt_next   = '0;
        end
      end
      S_WAIT: begin
        if (!dbg_req) begin
          state_next = S_IDLE;
          cnt_next   = '0;
          hold_next  = 1'b0;
        end else if (cpu_active) begin
          if (cnt_reg == LIMIT) begin
            hold_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end else begin
          state_next = dbg_we ? S_IDLE : S_RESP;
          cnt_next   = '0;
          hold_next  = 1'b0;
        end
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output logic: port mux and grant pulse; a cycle under reset never grants.
  always_comb begin
    grant         = (state_reg == S_WAIT) && dbg_req && !cpu_active && !reset;
    dbg_gnt       = grant;
    mem_addr      = cpu_addr;
    mem_wdata     = cpu_wdata;
    mem_memwrite  = cpu_memwrite;
    mem_memread   = cpu_memread;
    mem_sign_mask = cpu_sign_mask;
    if (grant) begin
      mem_addr      = dbg_addr;
      mem_wdata     = dbg_wdata;
      mem_memwrite  = dbg_we;
      mem_memread   = !dbg_we;
      mem_sign_mask = dbg_sign_mask;
    end
  end

  assign cpu_rdata  = mem_rdata;
  assign cpu_hold   = hold_reg;
  assign dbg_rdata  = rdata_reg;
  assign dbg_rvalid = rvalid_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter: a transaction-level model predicts
// grant cycles, port contents, read data and hold; a monitor compares every cycle.
module tb_dmem_arbiter;

  localparam int LIMIT = 4;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } txn_t;

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } gnt_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rv_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_memwrite, cpu_memread, cpu_hold;
  logic [3:0]  cpu_sign_mask;
  logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [3:0]  dbg_sign_mask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_memwrite, mem_memread;
  logic [3:0]  mem_sign_mask;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_memwrite(cpu_memwrite),
    .cpu_memread(cpu_memread), .cpu_sign_mask(cpu_sign_mask), .cpu_rdata(cpu_rdata),
    .cpu_hold(cpu_hold),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_sign_mask(dbg_sign_mask), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
    .dbg_rvalid(dbg_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_memwrite(mem_memwrite),
    .mem_memread(mem_memread), .mem_sign_mask(mem_sign_mask), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: 16 words, read data valid the cycle after the read strobe.
  logic [31:0] mem_arr [16];
  always @(posedge clk) begin
    if (mem_memwrite) mem_arr[mem_addr[5:2]] <= mem_wdata;
    if (mem_memread)  mem_rdata <= mem_arr[mem_addr[5:2]];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Scoreboard queues and observed-event logs.
  gnt_t gnt_q[$];
  rv_t  rv_q[$];
  bit   hold_q[$];
  int   dut_gnt_log[$];
  int   dut_rv_log[$];
  bit   mon_en = 1'b0;

  always @(negedge clk) begin : monitor
    bit   eg, ev, h;
    gnt_t g;
    rv_t  r;
    if (mon_en) begin
      if (dbg_gnt)    dut_gnt_log.push_back(cyc);
      if (dbg_rvalid) dut_rv_log.push_back(cyc);
      chk("cpu_rdata", cpu_rdata, mem_rdata);
      if (hold_q.size() > 0) begin
        h = hold_q.pop_front();
        chk("cpu_hold", cpu_hold, h);
      end
      eg = (gnt_q.size() > 0) && (gnt_q[0].cyc == cyc);
      chk("dbg_gnt", dbg_gnt, eg);
      if (eg) begin
        g = gnt_q.pop_front();
        chk("gnt_port", {mem_addr, mem_wdata, mem_memread, mem_memwrite, mem_sign_mask},
            {g.addr, g.wdata, !g.we, g.we, g.mask});
      end else begin
        chk("cpu_pass", {mem_addr, mem_wdata, mem_memread, mem_memwrite, mem_sign_mask},
            {cpu_addr, cpu_wdata, cpu_memread, cpu_memwrite, cpu_sign_mask});
      end
      ev = (rv_q.size() > 0) && (rv_q[0].cyc == cyc);
      chk("dbg_rvalid", dbg_rvalid, ev);
      if (ev) begin
        r = rv_q.pop_front();
        chk("dbg_rdata", dbg_rdata, r.data);
      end
    end
  end

  // Requester state and reference model state.
  txn_t        txq[$];
  txn_t        cur;
  bit          cur_valid = 1'b0;
  logic [31:0] ref_mem [16];
  bit          seen = 1'b0;
  int          nact = 0;
  int          free_at = 0;
  int          resp_at = -1;
  logic [31:0] resp_d;
  bit          hold_exp = 1'b0;

  function automatic txn_t mk_txn(input bit we, input int word, input logic [31:0] d);
    txn_t x;
    x.we    = we;
    x.addr  = 32'h1000 + 32'(word) * 4;
    x.wdata = d;
    x.mask  = 4'($urandom_range(0, 15));
    return x;
  endfunction

  // One clock cycle: drive inputs, advance the model, push expectations, wait for the edge.
  task automatic tick(input bit want_rd, input bit want_wr, input bit rst, input bit abort_now);
    int t;
    bit act;
    t = cyc;
    if (mon_en) hold_q.push_back(hold_exp);
    reset = rst;
    if (rst || hold_exp) begin
      want_rd = 1'b0;
      want_wr = 1'b0;
    end
    cpu_memread   = want_rd;
    cpu_memwrite  = want_wr && !want_rd;
    cpu_addr      = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
    cpu_wdata     = $urandom;
    cpu_sign_mask = 4'($urandom_range(0, 15));
    if (rst) cur_valid = 1'b0;
    else if (!cur_valid && txq.size() > 0) begin
      cur = txq.pop_front();
      cur_valid = 1'b1;
    end
    if (abort_now) cur_valid = 1'b0;
    dbg_req       = cur_valid;
    dbg_we        = cur.we;
    dbg_addr      = cur.addr;
    dbg_wdata     = cur.wdata;
    dbg_sign_mask = cur.mask;
    act = cpu_memread | cpu_memwrite;

    if (rst) begin
      seen = 1'b0; nact = 0; hold_exp = 1'b0; free_at = t + 1; resp_at = -1;
    end else begin
      if (resp_at == t) rv_q.push_back('{t + 1, resp_d});
      if (resp_at <= t) resp_at = -1;
      hold_exp = seen && dbg_req && act && (nact >= LIMIT);
      if (seen) begin
        if (!dbg_req) begin
          seen = 1'b0; nact = 0; free_at = t + 1;
        end else if (act) begin
          nact++;
        end else begin
          gnt_q.push_back('{t, cur.we, cur.addr, cur.wdata, cur.mask});
          if (cur.we) ref_mem[cur.addr[5:2]] = cur.wdata;
          else begin
            resp_at = t + 1;
            resp_d  = ref_mem[cur.addr[5:2]];
          end
          seen = 1'b0; nact = 0;
          free_at = cur.we ? t + 1 : t + 2;
          cur_valid = 1'b0;
        end
      end else if (dbg_req && t >= free_at) begin
        seen = 1'b1; nact = 0;
      end
      if (cpu_memwrite) ref_mem[cpu_addr[5:2]] = cpu_wdata;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic int first_of(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  initial begin
    int t0;
    bit busy;
    int r;
    cur = mk_txn(1'b0, 0, 32'h0);
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;

    // Reset state.
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    mon_en = 1'b1;
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_rdata", dbg_rdata, 32'h0);
    chk("rst_flags", {dbg_gnt, dbg_rvalid, cpu_hold}, 3'b000);

    // Back-to-back write then read, no contention.
    dut_gnt_log.delete(); dut_rv_log.delete();
    txq.push_back(mk_txn(1'b1, 0, 32'hDEADBEEF));
    txq.push_back(mk_txn(1'b0, 0, 32'h0));
    t0 = cyc;
    idle(8);
    chk("b2b_gnt_w", first_of(dut_gnt_log), t0 + 1);
    chk("b2b_gnt_r", (dut_gnt_log.size() > 1) ? dut_gnt_log[1] : -1, t0 + 3);
    chk("b2b_rv", first_of(dut_rv_log), t0 + 5);
    chk("b2b_rdata", dbg_rdata, 32'hDEADBEEF);

    // Fill the remaining words so later reads have defined contents.
    for (int i = 1; i < 16; i++) txq.push_back(mk_txn(1'b1, i, $urandom));
    idle(40);

    // CPU contention: five cycles of CPU reads while a dbg read waits.
    dut_gnt_log.delete(); dut_rv_log.delete();
    txq.push_back(mk_txn(1'b0, 5, 32'h0));
    t0 = cyc;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    chk("cont_gnt", first_of(dut_gnt_log), t0 + 5);
    chk("cont_rv", first_of(dut_rv_log), t0 + 7);

    // Starvation: CPU stays busy until held.
    dut_gnt_log.delete();
    txq.push_back(mk_txn(1'b1, 7, 32'hA5A5_0707));
    t0 = cyc;
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("starve_gnt", first_of(dut_gnt_log), t0 + 6);
    idle(3);

    // Abort under contention.
    dut_gnt_log.delete();
    txq.push_back(mk_txn(1'b0, 3, 32'h0));
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("abort_nognt", dut_gnt_log.size(), 0);
    chk("abort_hold", cpu_hold, 1'b0);
    idle(2);

    // Reset in the RESP cycle.
    dut_rv_log.delete();
    txq.push_back(mk_txn(1'b0, 9, 32'h0));
    idle(2);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    chk("rstresp_norv", dut_rv_log.size(), 0);
    chk("rstresp_rdata", dbg_rdata, 32'h0);

    // Randomized traffic with alternating busy/light CPU phases.
    busy = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i % 16 == 0) busy = ($urandom_range(0, 1) == 1);
      if (txq.size() == 0 && $urandom_range(0, 99) < 40)
        txq.push_back(mk_txn($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom));
      r = $urandom_range(0, 99);
      tick(r < (busy ? 60 : 15), r >= (busy ? 60 : 15) && r < (busy ? 92 : 30),
           (i == 300), cur_valid && seen && ($urandom_range(0, 99) < 2));
    end
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
